csla_64bit: RTL and testbench
=============================

CSLA_64BIT -- requirements
Module: csla_64bit

Interface
REQ-001 SHALL expose parameter BLOCK_W, default 4, meaning the bit width of each carry-select block; legal values are 4, 8 and 16, each dividing 64.
REQ-002 SHALL expose port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL expose port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL expose port a, input, 64 bits: addend A, unsigned.
REQ-005 SHALL expose port b, input, 64 bits: addend B, unsigned.
REQ-006 SHALL expose port cin, input, 1 bit: carry-in.
REQ-007 SHALL expose port sum, output, 64 bits: registered sum bits [63:0].
REQ-008 SHALL expose port cout, output, 1 bit: registered carry-out (bit 64 of the result).

Function
REQ-009 SHALL compute the combinational result {c64, s[63:0]} = a + b + cin, exact to 65 bits with no truncation or saturation.
REQ-010 SHALL build the adder as a carry-select adder with 64/BLOCK_W blocks.
REQ-011 Block 0 SHALL be one ripple-carry adder fed directly by cin.
REQ-012 Each block k >= 1 SHALL contain two ripple-carry adders of BLOCK_W bits each, one with carry-in 0 and one with carry-in 1.
REQ-013 For each block k >= 1, the carry-out of block k-1 SHALL select that block's sum bits and carry-out through a 2:1 mux.
REQ-014 The ripple adders SHALL be made of full-adder cells: s = x^y^c, co = (x&y)|(c&(x^y)).
REQ-015 Behavioural "+" SHALL NOT be used for the datapath.
REQ-016 The carry-out of the last block SHALL be c64.
REQ-017 On each rising clk edge with rst_n high, sum SHALL load s[63:0] and cout SHALL load c64, giving a latency of exactly 1 cycle.
REQ-018 The adder SHALL accept a new operand set every cycle (throughput 1 per cycle) with no handshake.
REQ-019 Wrap-around: when a + b + cin >= 2^64, sum SHALL equal (a + b + cin) mod 2^64 and cout SHALL be 1; otherwise cout SHALL be 0.
REQ-020 The result SHALL be the same for every legal BLOCK_W.
REQ-021 Outputs SHALL change only on a clk edge or on reset assertion, never combinationally from the inputs.

Reset
REQ-022 While rst_n is low, sum SHALL be 64'd0 and cout SHALL be 0, asynchronously (without waiting for a clk edge).
REQ-023 Reset asserted mid-operation SHALL discard the pending result.
REQ-024 After rst_n deasserts, the first rising clk edge SHALL register the inputs present at that edge.
REQ-025 The combinational datapath SHALL hold no state and SHALL NOT be affected by reset.

Verification
REQ-026 a=10, b=35, cin=0 -> one cycle later sum=45, cout=0.
REQ-027 a=23, b=132, cin=1 -> sum=156, cout=0.
REQ-028 a=3846, b=9654, cin=0 -> sum=13500, cout=0.
REQ-029 a=866945, b=3324752, cin=1 -> sum=4191698, cout=0.
REQ-030 a=6223372036854775808, b=38701384792384, cin=1 -> sum=6223410738239568193, cout=0.
REQ-031 Carry ripple across every block boundary: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1.
REQ-032 a=b=64'hFFFF_FFFF_FFFF_FFFF, cin=1 -> sum=64'hFFFF_FFFF_FFFF_FFFF, cout=1.
REQ-033 Streaming and reset: apply three distinct operand sets on back-to-back cycles -> each result appears exactly one cycle after its inputs.
REQ-034 Pulse rst_n low between clk edges -> sum=0 and cout=0 immediately; the next edge after release registers the current inputs.
REQ-035 Random check: at least 10,000 random (a, b, cin) triples for each BLOCK_W in {4, 8, 16} -> {cout, sum} matches a 65-bit reference model.

Source files
------------

// File: rtl/csla_64bit.sv
// 64-bit carry-select adder with a registered result (1-cycle latency).
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst_n  in   1   asynchronous active-low reset, clears sum/cout
//   a      in  64   addend A (unsigned)
//   b      in  64   addend B (unsigned)
//   cin    in   1   carry-in
//   sum    out 64   registered (a + b + cin) mod 2^64
//   cout   out  1   registered bit 64 of a + b + cin
//
// BLOCK_W sets the carry-select block width; legal values are 4, 8 and 16.

// Ripple-carry adder built from full-adder cells.
module csla_rca #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   input  logic         ci_i,
   output logic [W-1:0] s_o,
   output logic         co_o
);

   logic [W:0] c;

   assign c[0] = ci_i;

   for (genvar i = 0; i < W; i++) begin : g_fa
      assign s_o[i]  = x_i[i] ^ y_i[i] ^ c[i];
      assign c[i+1]  = (x_i[i] & y_i[i]) | (c[i] & (x_i[i] ^ y_i[i]));
   end

   assign co_o = c[W];

endmodule

module csla_64bit #(
   parameter int unsigned BLOCK_W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        cin,
   output logic [63:0] sum,
   output logic        cout
);

   localparam int unsigned DATA_W = 64;
   localparam int unsigned N_BLK  = DATA_W / BLOCK_W;

   // blk_c[k] is the carry into block k; blk_c[N_BLK] is bit 64 of the result.
   logic [N_BLK:0]    blk_c;
   logic [DATA_W-1:0] s_c;

   logic [DATA_W-1:0] sum_d, sum_q;
   logic              cout_d, cout_q;

   assign blk_c[0] = cin;

   for (genvar k = 0; k < int'(N_BLK); k++) begin : g_blk
      if (k == 0) begin : g_ripple
         // First block has a real carry-in, so a single ripple chain suffices.
         csla_rca #(.W(BLOCK_W)) u_rca (
            .x_i  (a[0 +: BLOCK_W]),
            .y_i  (b[0 +: BLOCK_W]),
            .ci_i (blk_c[0]),
            .s_o  (s_c[0 +: BLOCK_W]),
            .co_o (blk_c[1])
         );
      end else begin : g_select
         logic [BLOCK_W-1:0] s0, s1;
         logic               c0, c1;

         // Both carry hypotheses are precomputed; the incoming carry only picks one.
         csla_rca #(.W(BLOCK_W)) u_rca0 (
            .x_i  (a[k*BLOCK_W +: BLOCK_W]),
            .y_i  (b[k*BLOCK_W +: BLOCK_W]),
            .ci_i (1'b0),
            .s_o  (s0),
            .co_o (c0)
         );

         csla_rca #(.W(BLOCK_W)) u_rca1 (
            .x_i  (a[k*BLOCK_W +: BLOCK_W]),
            .y_i  (b[k*BLOCK_W +: BLOCK_W]),
            .ci_i (1'b1),
            .s_o  (s1),
            .co_o (c1)
         );

         assign s_c[k*BLOCK_W +: BLOCK_W] = blk_c[k] ? s1 : s0;
         assign blk_c[k+1]                = blk_c[k] ? c1 : c0;
      end
   end

   // Next-state for the output register.
   always_comb begin
      sum_d  = s_c;
      cout_d = blk_c[N_BLK];
   end

   // Output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_csla_64bit.sv
// Self-checking bench for csla_64bit: one instance per legal BLOCK_W, all
// driven by the same operands and compared against a 65-bit arithmetic model.
module tb_csla_64bit;

   logic        clk;
   logic        rst_n;
   logic [63:0] a, b;
   logic        cin;

   logic [63:0] sum4, sum8, sum16;
   logic        cout4, cout8, cout16;

   int unsigned n_tests;
   int unsigned n_fail;

   csla_64bit #(.BLOCK_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .sum(sum4), .cout(cout4)
   );
   csla_64bit #(.BLOCK_W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .sum(sum8), .cout(cout8)
   );
   csla_64bit #(.BLOCK_W(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .sum(sum16), .cout(cout16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: exact 65-bit sum.
   function automatic logic [64:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                           input logic ci);
      return {1'b0, x} + {1'b0, y} + 65'(ci);
   endfunction

   task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got cout=%0b sum=%h, expected cout=%0b sum=%h",
                  tag, got[64], got[63:0], exp[64], exp[63:0]);
      end
   endtask

   task automatic chk_all(input string tag, input logic [64:0] exp);
      chk({tag, "/bw4"},  {cout4,  sum4},  exp);
      chk({tag, "/bw8"},  {cout8,  sum8},  exp);
      chk({tag, "/bw16"}, {cout16, sum16}, exp);
   endtask

   // Present operands at the falling edge, check just after the next rising edge.
   task automatic apply_chk(input string tag, input logic [63:0] x, input logic [63:0] y,
                            input logic ci);
      @(negedge clk);
      a = x; b = y; cin = ci;
      @(posedge clk);
      #1;
      chk_all(tag, ref_add(x, y, ci));
   endtask

   logic [64:0] prev_exp;
   logic [63:0] ra, rb;
   logic        rc;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b1;
      a = 64'd0; b = 64'd0; cin = 1'b0;

      // Async reset with no clock edge involved.
      #1 rst_n = 1'b0;
      #1 chk_all("reset_async", 65'd0);

      // Operands applied during reset must not be registered.
      a = 64'd123; b = 64'd456; cin = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk_all("reset_hold", 65'd0);

      @(negedge clk);
      rst_n = 1'b1;
      a = 64'd7; b = 64'd8; cin = 1'b0;
      @(posedge clk);
      #1 chk_all("first_edge", 65'd15);

      // Directed vectors.
      apply_chk("v026", 64'd10, 64'd35, 1'b0);
      apply_chk("v027", 64'd23, 64'd132, 1'b1);
      apply_chk("v028", 64'd3846, 64'd9654, 1'b0);
      apply_chk("v029", 64'd866945, 64'd3324752, 1'b1);
      apply_chk("v030", 64'd6223372036854775808, 64'd38701384792384, 1'b1);
      chk_all("v030_const", {1'b0, 64'd6223410738239568193});
      apply_chk("v031", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
      chk_all("v031_const", {1'b1, 64'd0});
      apply_chk("v032", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      chk_all("v032_const", {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
      apply_chk("wrap", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
      apply_chk("cin_only", 64'd0, 64'd0, 1'b1);
      apply_chk("alt_prop", 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1);

      // Streaming: result must not move before the edge, and must follow it by one cycle.
      prev_exp = ref_add(64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a   = 64'h0123_4567_89AB_CDEF ^ (64'(i) << 17);
         b   = 64'hFEDC_BA98_7654_3210 + 64'(i * 1000);
         cin = i[0];
         #1 chk_all($sformatf("stream%0d_hold", i), prev_exp);
         prev_exp = ref_add(a, b, cin);
         @(posedge clk);
         #1 chk_all($sformatf("stream%0d", i), prev_exp);
      end

      // Reset pulse between edges.
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 chk_all("pulse_clear", 65'd0);
      a = 64'hDEAD_BEEF_0000_0001; b = 64'h2152_4110_FFFF_FFFF; cin = 1'b0;
      #1 rst_n = 1'b1;
      #1 chk_all("pulse_released", 65'd0);
      @(posedge clk);
      #1 chk_all("pulse_next_edge", ref_add(a, b, cin));

      // Random streaming check, with some operands forced to carry-propagate patterns.
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         ra = {$urandom, $urandom};
         rc = 1'($urandom);
         case ($urandom_range(7))
            0:       rb = ~ra;
            1:       rb = 64'hFFFF_FFFF_FFFF_FFFF;
            2:       rb = (~ra) ^ (64'd1 << $urandom_range(63));
            default: rb = {$urandom, $urandom};
         endcase
         a = ra; b = rb; cin = rc;
         @(posedge clk);
         #1 chk_all($sformatf("rand%0d", i), ref_add(ra, rb, rc));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard bound so the run always terminates.
   initial begin
      #2_000_000;
      $display("FAIL timeout: got no completion, expected finish before 2000000");
      $fatal(1);
   end

endmodule
